// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scan sequencer driving 4:1 mux selects and capturing F per channel
// Walks enabled channels in ascending order, dwells DWELL cycles on each, then samples F.
module mux_scan_sequencer #(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] EN_MASK,
  input  logic       F,
  output logic       S1,
  output logic       S2,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] SAMPLES
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [3:0]       mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       samples_q;

  logic [1:0]       first_idx;
  logic [1:0]       next_idx;
  logic             has_next;

  // Descending loops so the last hit is the lowest qualifying index.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (EN_MASK[i]) first_idx = 2'(i);
    end
    has_next = 1'b0;
    next_idx = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        has_next = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      mask_q    <= 4'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      samples_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            mask_q    <= EN_MASK;
            samples_q <= 4'd0;
            if (EN_MASK != 4'd0) begin
              sel_q   <= first_idx;
              cnt_q   <= DWELL_M1;
              busy_q  <= 1'b1;
              state_q <= SETTLE;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= CAPTURE;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        CAPTURE: begin
          samples_q[sel_q] <= F;
          // Selects advance on this same edge so the next channel gets the full dwell.
          if (has_next) begin
            sel_q   <= next_idx;
            cnt_q   <= DWELL_M1;
            state_q <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S1      = sel_q[1];
  assign S2      = sel_q[0];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign SAMPLES = samples_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer
// Two instances: DWELL=2 with a modelled mux on F, DWELL=1 with F driven directly.
module tb_mux_scan_sequencer;

  localparam int D2 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start1, f1;
  logic [3:0] en_mask, data2;
  logic       f2;
  logic       s1_2, s2_2, busy2, done2;
  logic [3:0] samples2;
  logic       s1_1, s2_1, busy1, done1;
  logic [3:0] samples1;

  always #5 clk = ~clk;

  assign f2 = data2[{s1_2, s2_2}];

  mux_scan_sequencer #(.DWELL(2), .CNT_W(8)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .EN_MASK(en_mask), .F(f2),
    .S1(s1_2), .S2(s2_2), .BUSY(busy2), .DONE(done2), .SAMPLES(samples2)
  );

  mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .EN_MASK(en_mask), .F(f1),
    .S1(s1_1), .S2(s2_1), .BUSY(busy1), .DONE(done1), .SAMPLES(samples1)
  );

  typedef struct packed {
    logic [1:0] s;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t       sb[$];
  logic [1:0] model_s;
  int         n_checks = 0;
  int         n_fails  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle {S,BUSY,DONE} is queued at stimulus time, then popped each cycle.
  task automatic scan2(input string name, input logic [3:0] mask, input logic [3:0] data,
                       input logic [3:0] exp_samples, input bit poke);
    obs_t o;
    int   idx;
    for (int j = 0; j < 4; j++) begin
      if (mask[j]) begin
        for (int k = 0; k < D2 + 1; k++) sb.push_back({2'(j), 1'b1, 1'b0});
        model_s = 2'(j);
      end
    end
    sb.push_back({model_s, 1'b0, 1'b1});
    sb.push_back({model_s, 1'b0, 1'b0});
    @(negedge clk);
    data2   = data;
    en_mask = mask;
    start2  = 1'b1;
    idx     = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = sb.pop_front();
      chk($sformatf("%s cyc%0d", name, idx), {4'd0, s1_2, s2_2, busy2, done2}, {4'd0, o});
      if (idx == 0) start2 = 1'b0;
      if (poke && idx == 4) begin
        start2  = 1'b1;
        en_mask = 4'b0001;
      end
      if (poke && idx == 5) start2 = 1'b0;
      idx++;
    end
    chk({name, " samples"}, {4'd0, samples2}, {4'd0, exp_samples});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n   = 1'b0;
    start2  = 1'b0;
    start1  = 1'b0;
    f1      = 1'b0;
    en_mask = 4'd0;
    data2   = 4'd0;
    model_s = 2'd0;

    @(negedge clk);
    chk("reset dut2", {s1_2, s2_2, busy2, done2, samples2}, 8'd0);
    chk("reset dut1", {s1_1, s2_1, busy1, done1, samples1}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    scan2("full", 4'b1111, 4'b1101, 4'b1101, 1'b0);

    // Second scan interrupted by reset while on channel B.
    @(negedge clk);
    en_mask = 4'b1111;
    data2   = 4'b1101;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midscan chB", {5'd0, s1_2, s2_2, busy2}, {5'd0, 2'b01, 1'b1});
    chk("midscan chA captured", {4'd0, samples2}, 8'h01);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", {s1_2, s2_2, busy2, done2, samples2}, 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("reset held no done", {7'd0, done2}, 8'd0);
    end
    rst_n   = 1'b1;
    model_s = 2'd0;
    repeat (2) @(negedge clk);
    chk("after reset idle", {s1_2, s2_2, busy2, done2, samples2}, 8'd0);

    scan2("sparse", 4'b1010, 4'b0010, 4'b0010, 1'b0);
    scan2("empty", 4'b0000, 4'b1111, 4'b0000, 1'b0);
    scan2("ignored", 4'b1111, 4'b0110, 4'b0110, 1'b1);

    // DWELL=1: F rises during the single SETTLE cycle; START held for back-to-back.
    @(negedge clk);
    en_mask = 4'b0001;
    f1      = 1'b0;
    start1  = 1'b1;
    @(negedge clk);
    chk("d1 settle", {5'd0, s1_1, s2_1, busy1}, {5'd0, 2'b00, 1'b1});
    f1 = 1'b1;
    @(negedge clk);
    chk("d1 capture", {6'd0, busy1, done1}, 8'b10);
    @(negedge clk);
    chk("d1 done", {2'd0, busy1, done1, samples1}, {2'd0, 1'b0, 1'b1, 4'b0001});
    f1  = 1'b0;
    cnt = 0;
    while (!busy1 && cnt < 3) begin
      @(negedge clk);
      cnt++;
    end
    chk("d1 restart busy", {7'd0, busy1}, 8'd1);
    chk("d1 restart cleared", {4'd0, samples1}, 8'd0);
    start1 = 1'b0;
    cnt = 0;
    while (!done1 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("d1 second done", {7'd0, done1}, 8'd1);
    chk("d1 second samples", {4'd0, samples1}, 8'd0);
    @(negedge clk);
    chk("d1 back idle", {6'd0, busy1, done1}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
